// File: rtl/out_port_tx.sv
// out_port_tx: queues 16-bit core output words in a small FIFO and sends
// each one as two 8N1 frames, high byte first, on a registered txd line.
// Ports: clk, reset (sync, active high); out_en/out_dat word strobe;
// is_halt core halt; txd serial out; busy frame active; count FIFO fill;
// overflow sticky drop flag; drained halt seen and everything sent.
module out_port_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        out_en,
  input  logic [15:0] out_dat,
  input  logic        is_halt,
  output logic        txd,
  output logic        busy,
  output logic [4:0]  count,
  output logic        overflow,
  output logic        drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [4:0]    FULL    = 5'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;
  logic          drained_q, drained_d;
  logic          txd_q, txd_d;

  logic push;
  logic pop;
  logic bit_tick;

  always_comb begin
    pop  = (state_q == IDLE) && (count_q != 5'd0);
    // A full FIFO still takes the word when the serializer frees a slot.
    push = out_en && ((count_q != FULL) || pop);
    bit_tick = (cnt_q == CNT_MAX);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = out_dat;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q | (out_en & ~push);
    halt_d     = halt_q | is_halt;
    drained_d  = halt_q && (count_q == 5'd0) && (state_q == IDLE);

    state_d    = state_q;
    cnt_d      = bit_tick ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    txd_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (pop) begin
          hold_d     = mem_q[rd_ptr_q];
          byte_sel_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_tick) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd_d = byte_sel_q ? hold_q[{1'b0, idx_q}]
                           : hold_q[{1'b1, idx_q}];
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      byte_sel_q <= 1'b0;
      hold_q     <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      drained_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_sel_q <= byte_sel_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      drained_q  <= drained_d;
      txd_q      <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drained  = drained_q;

endmodule

// File: tb/tb_out_port_tx.sv
// tb_out_port_tx: directed checks of out_port_tx framing, FIFO limits,
// reset abort and drain signalling with CLKS_PER_BIT=4, DEPTH=8.
module tb_out_port_tx;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_en;
  logic [15:0] out_dat;
  logic        is_halt;
  logic        txd;
  logic        busy;
  logic [4:0]  count;
  logic        overflow;
  logic        drained;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  out_port_tx #(
    .DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .out_en(out_en),
    .out_dat(out_dat),
    .is_halt(is_halt),
    .txd(txd),
    .busy(busy),
    .count(count),
    .overflow(overflow),
    .drained(drained)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected line level for frame bit b (0..19) of word w.
  function automatic logic frame_bit(input logic [15:0] w, input int b);
    int pos;
    logic [7:0] by;
    pos = b % 10;
    by = (b < 10) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[3'(pos - 1)];
  endfunction

  // Samples one 8N1 byte mid-bit, starting from the first low cycle.
  task automatic rx_byte(input string tag, output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (txd !== 1'b0 && n < 400) begin
      cyc(1);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(n < 400), 32'(1));
    if (n >= 400) return;
    cyc(CPB / 2);
    chk({tag, "_start"}, 32'(txd), 32'(0));
    for (int k = 0; k < 8; k++) begin
      cyc(CPB);
      b[k] = txd;
    end
    cyc(CPB);
    chk({tag, "_stop"}, 32'(txd), 32'(1));
  endtask

  task automatic rx_word(input string tag, input logic [15:0] exp);
    logic [7:0] hi;
    logic [7:0] lo;
    rx_byte(tag, hi);
    rx_byte(tag, lo);
    chk(tag, 32'({hi, lo}), 32'(exp));
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    out_en  = 1'b0;
    is_halt = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int bn;
    int bad;

    // Reset with out_en held high: the word must be ignored.
    reset   = 1'b1;
    out_en  = 1'b1;
    out_dat = 16'hBEEF;
    is_halt = 1'b0;
    cyc(3);
    chk("rst_txd", 32'(txd), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_drained", 32'(drained), 32'(0));
    reset  = 1'b0;
    out_en = 1'b0;
    cyc(1);
    chk("rst_en_ignored", 32'(count), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));

    // Single word 0xA55A: write edge, pop edge, then txd low one edge later.
    out_en  = 1'b1;
    out_dat = 16'hA55A;
    cyc(1);
    out_en = 1'b0;
    chk("wr_count", 32'(count), 32'(1));
    chk("wr_busy", 32'(busy), 32'(0));
    chk("wr_txd", 32'(txd), 32'(1));
    cyc(1);
    chk("pop_busy", 32'(busy), 32'(1));
    chk("pop_count", 32'(count), 32'(0));
    chk("pop_txd_lag", 32'(txd), 32'(1));
    bn = 1;
    for (int i = 2; i <= 81; i++) begin
      cyc(1);
      chk("a55a_txd", 32'(txd), 32'(frame_bit(16'hA55A, (i - 2) / CPB)));
      if (busy === 1'b1) bn++;
    end
    chk("a55a_busy_cycles", 32'(bn), 32'(20 * CPB));
    cyc(1);
    chk("a55a_idle_txd", 32'(txd), 32'(1));
    chk("a55a_idle_busy", 32'(busy), 32'(0));

    // Ten consecutive words into an 8-deep FIFO: word 10 is dropped.
    do_reset;
    fork
      begin
        for (int k = 1; k <= 10; k++) begin
          out_en  = 1'b1;
          out_dat = 16'(k);
          cyc(1);
          if (k == 1) chk("ovf_cnt1", 32'(count), 32'(1));
          if (k == 2) chk("ovf_pop_e2", 32'(busy), 32'(1));
          if (k == 2) chk("ovf_cnt2", 32'(count), 32'(1));
          if (k == 9) chk("ovf_full", 32'(count), 32'(8));
          if (k == 9) chk("ovf_not_yet", 32'(overflow), 32'(0));
          if (k == 10) chk("ovf_cnt10", 32'(count), 32'(8));
          if (k == 10) chk("ovf_set", 32'(overflow), 32'(1));
        end
        out_en = 1'b0;
      end
      begin
        for (int w = 1; w <= 9; w++) begin
          rx_word("ovf_word", 16'(w));
        end
      end
    join
    cyc(10);
    chk("ovf_empty", 32'(count), 32'(0));
    chk("ovf_sticky", 32'(overflow), 32'(1));
    chk("ovf_done_busy", 32'(busy), 32'(0));

    // Full FIFO, push on the pop edge is accepted without overflow.
    do_reset;
    for (int k = 1; k <= 9; k++) begin
      out_en  = 1'b1;
      out_dat = 16'h0100 + 16'(k);
      cyc(1);
    end
    out_en = 1'b0;
    chk("fp_full", 32'(count), 32'(8));
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("fp_idle_seen", 32'(n < 200), 32'(1));
    out_en  = 1'b1;
    out_dat = 16'h0BAD;
    cyc(1);
    chk("fp_cnt_same", 32'(count), 32'(8));
    chk("fp_no_ovf", 32'(overflow), 32'(0));
    chk("fp_busy", 32'(busy), 32'(1));
    out_dat = 16'h0DAD;
    cyc(1);
    out_en = 1'b0;
    chk("fp_drop_ovf", 32'(overflow), 32'(1));
    chk("fp_drop_cnt", 32'(count), 32'(8));

    // Reset during data bit 3 of the first byte aborts everything.
    do_reset;
    out_en  = 1'b1;
    out_dat = 16'h1234;
    cyc(1);
    out_dat = 16'h5678;
    cyc(1);
    out_en = 1'b0;
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("ra_start_seen", 32'(n < 20), 32'(1));
    cyc(CPB + 3 * CPB);
    chk("ra_bit3", 32'(txd), 32'(frame_bit(16'h1234, 4)));
    reset = 1'b1;
    cyc(1);
    chk("ra_txd", 32'(txd), 32'(1));
    chk("ra_busy", 32'(busy), 32'(0));
    chk("ra_count", 32'(count), 32'(0));
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("ra_silent", 32'(bad), 32'(0));

    // Two words, one-cycle halt pulse, then drained after the last frame.
    do_reset;
    out_en  = 1'b1;
    out_dat = 16'hC001;
    cyc(1);
    out_dat = 16'hC002;
    is_halt = 1'b1;
    cyc(1);
    out_en  = 1'b0;
    is_halt = 1'b0;
    chk("dr_early", 32'(drained), 32'(0));
    n = 0;
    bad = 0;
    while (!(busy === 1'b0 && count === 5'd0) && n < 400) begin
      if (drained !== 1'b0) bad++;
      cyc(1);
      n++;
    end
    chk("dr_idle_seen", 32'(n < 400), 32'(1));
    chk("dr_low_while_busy", 32'(bad), 32'(0));
    chk("dr_at_idle", 32'(drained), 32'(0));
    cyc(1);
    chk("dr_set", 32'(drained), 32'(1));
    cyc(5);
    chk("dr_stays", 32'(drained), 32'(1));
    out_en  = 1'b1;
    out_dat = 16'hD00D;
    cyc(1);
    out_en = 1'b0;
    chk("dr_post_halt_q", 32'(count), 32'(1));
    rx_word("dr_post_halt", 16'hD00D);
    cyc(4);
    chk("dr_reset_again", 32'(drained), 32'(1));

    // Back-to-back words: stop bit, one idle cycle, next start.
    do_reset;
    out_en  = 1'b1;
    out_dat = 16'h0F0F;
    cyc(1);
    out_dat = 16'hF0F0;
    cyc(1);
    out_en = 1'b0;
    rx_word("bb_w1", 16'h0F0F);
    // rx_word returns mid stop bit (its third cycle); one more stop cycle
    // and one idle cycle precede the next start bit.
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("bb_gap", 32'(n), 32'(CPB / 2 + 1));
    rx_word("bb_w2", 16'hF0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
